// File: rtl/bayer_line_buffer.sv
// One-line circular buffer feeding the 2x2 Bayer greyscale stage: for every accepted
// pixel it emits the current pixel, the same-column pixel from the previous row, and x/y.
module bayer_line_buffer #(
  parameter int LINE_WIDTH  = 8,
  parameter int FRAME_LINES = 6,
  parameter int DW          = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] pixel_in,
  input  logic          pixel_valid,
  input  logic          sof,
  output logic [DW-1:0] tap0,
  output logic [DW-1:0] tap1,
  output logic          tap_valid,
  output logic [10:0]   x,
  output logic [10:0]   y
);

  localparam int CW = (LINE_WIDTH  > 1) ? $clog2(LINE_WIDTH)  : 1;
  localparam int RW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_LINES - 1);

  logic [DW-1:0] mem [LINE_WIDTH];

  logic [CW-1:0] wcol_q, wcol_d;
  logic [RW-1:0] wrow_q, wrow_d;
  logic          first_q, first_d;
  logic [DW-1:0] tap0_q, tap0_d;
  logic [DW-1:0] tap1_q, tap1_d;
  logic          tap_valid_q, tap_valid_d;
  logic [10:0]   x_q, x_d;
  logic [10:0]   y_q, y_d;

  // sof re-anchors the accepted pixel to (0,0) on the first row, whatever the counters say.
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic          cur_first;
  logic [DW-1:0] mem_rd;

  assign cur_col   = sof ? '0   : wcol_q;
  assign cur_row   = sof ? '0   : wrow_q;
  assign cur_first = sof ? 1'b1 : first_q;
  assign mem_rd    = mem[cur_col];

  always_comb begin
    wcol_d      = wcol_q;
    wrow_d      = wrow_q;
    first_d     = first_q;
    tap0_d      = tap0_q;
    tap1_d      = tap1_q;
    tap_valid_d = 1'b0;
    x_d         = x_q;
    y_d         = y_q;
    if (pixel_valid) begin
      tap_valid_d = 1'b1;
      tap1_d      = pixel_in;
      tap0_d      = cur_first ? '0 : mem_rd;
      x_d         = 11'(cur_col);
      y_d         = 11'(cur_row);
      if (cur_col == COL_LAST) begin
        wcol_d = '0;
        if (cur_row == ROW_LAST) begin
          wrow_d  = '0;
          first_d = 1'b1;
        end else begin
          wrow_d  = cur_row + RW'(1);
          first_d = 1'b0;
        end
      end else begin
        wcol_d  = cur_col + CW'(1);
        wrow_d  = cur_row;
        first_d = cur_first;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcol_q      <= '0;
      wrow_q      <= '0;
      first_q     <= 1'b1;
      tap0_q      <= '0;
      tap1_q      <= '0;
      tap_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      wcol_q      <= wcol_d;
      wrow_q      <= wrow_d;
      first_q     <= first_d;
      tap0_q      <= tap0_d;
      tap1_q      <= tap1_d;
      tap_valid_q <= tap_valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  // Memory is never cleared; stale contents are hidden by the first-row mask instead.
  always_ff @(posedge clk) begin
    if (pixel_valid && !rst) mem[cur_col] <= pixel_in;
  end

  assign tap0      = tap0_q;
  assign tap1      = tap1_q;
  assign tap_valid = tap_valid_q;
  assign x         = x_q;
  assign y         = y_q;

endmodule
